// File: rtl/tx_arbiter_pkg.sv
// Shared types and constants for the UART packet arbiter.
package tx_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;
   localparam logic [3:0] HDR_NIBBLE = 4'hA;
   localparam logic [1:0] LAST_IDX   = 2'd2;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: nearest requester after i_last, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int IDW     = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDW-1:0]     i_last,
   output logic               o_valid,
   output logic [IDW-1:0]     o_grant
);
   int w_dist;
   int w_best;

   // Distance 0 is the requester right after i_last; the smallest distance wins.
   always_comb begin
      o_valid = 1'b0;
      o_grant = '0;
      w_best  = NUM_REQ;
      w_dist  = 0;
      for (int j = 0; j < NUM_REQ; j++) begin
         w_dist = (j + 2 * NUM_REQ - 1 - int'(i_last)) % NUM_REQ;
         if (i_req[j] && (w_dist < w_best)) begin
            w_best  = w_dist;
            o_valid = 1'b1;
            o_grant = IDW'(j);
         end
      end
   end
endmodule

// File: rtl/tx_arbiter.sv
// Grants requesters round-robin and sends each latched word as a 3-byte
// packet (header, upper, lower) through one shared UART transmitter.
module tx_arbiter
   import tx_arbiter_pkg::*;
#(
   parameter  int NUM_REQ    = 3,
   parameter  int WORD_WIDTH = 16,
   localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          rst_in,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ*WORD_WIDTH-1:0] data_i,
   output logic [NUM_REQ-1:0]            ack_o,
   output logic [7:0]                    byte_o,
   output logic                          start_o,
   input  logic                          tx_done_i,
   output logic                          busy_o,
   output logic [IDW-1:0]                grant_id_o
);
   state_t                r_state, w_next;
   logic [1:0]            r_idx;
   logic [IDW-1:0]        r_id, r_last, w_gnt;
   logic                  w_valid, w_grant, w_adv, w_done;
   logic [WORD_WIDTH-1:0] r_word, w_word;
   logic [7:0]            r_byte, w_upper;
   logic [NUM_REQ-1:0]    r_ack, w_ack;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr (
      .i_req   (req_i),
      .i_last  (r_last),
      .o_valid (w_valid),
      .o_grant (w_gnt)
   );

   always_comb begin
      w_word = '0;
      for (int j = 0; j < NUM_REQ; j++)
         if (w_gnt == IDW'(j)) w_word = data_i[j*WORD_WIDTH +: WORD_WIDTH];
   end

   assign w_upper = 8'(r_word >> 8);

   // No grant while ack is showing, so a requester holding req_i re-arbitrates
   // only in the cycle after its ack.
   always_comb begin
      w_next  = r_state;
      w_grant = 1'b0;
      w_adv   = 1'b0;
      w_done  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_valid && (r_ack == '0)) begin
               w_grant = 1'b1;
               w_next  = START;
            end
         end
         START: begin
            if (!tx_done_i) w_next = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (tx_done_i) begin
               if (r_idx < LAST_IDX) begin
                  w_adv  = 1'b1;
                  w_next = START;
               end else begin
                  w_done = 1'b1;
                  w_next = IDLE;
               end
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_ack = '0;
      for (int j = 0; j < NUM_REQ; j++)
         if (w_done && (r_id == IDW'(j))) w_ack[j] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst_in) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         r_idx  <= '0;
         r_id   <= '0;
         r_last <= IDW'(NUM_REQ - 1);
         r_word <= '0;
         r_byte <= '0;
         r_ack  <= '0;
      end else begin
         r_ack <= w_ack;
         if (w_grant) begin
            r_id   <= w_gnt;
            r_last <= w_gnt;
            r_word <= w_word;
            r_byte <= {HDR_NIBBLE, 4'(w_gnt)};
            r_idx  <= '0;
         end
         if (w_adv) begin
            r_idx  <= r_idx + 2'd1;
            r_byte <= (r_idx == 2'd0) ? w_upper : r_word[7:0];
         end
      end
   end

   assign ack_o      = r_ack;
   assign byte_o     = r_byte;
   assign start_o    = (r_state == START);
   assign busy_o     = (r_state != IDLE);
   assign grant_id_o = r_id;
endmodule

// File: tb/tb_tx_arbiter.sv
// Scoreboard bench for tx_arbiter: expected bytes/acks queued at stimulus,
// compared against bytes captured on each start_o rise and ack pulses.
module tb_tx_arbiter;
   localparam int NR = 3;
   localparam int WW = 16;

   logic             clk = 1'b0;
   logic             rst_in;
   logic [NR-1:0]    req_i;
   logic [NR*WW-1:0] data_i;
   logic [NR-1:0]    ack_o;
   logic [7:0]       byte_o;
   logic             start_o;
   logic             tx_done_i;
   logic             busy_o;
   logic [1:0]       grant_id_o;

   logic             rst2;
   logic [2:0]       req2;
   logic [38:0]      data2;
   logic [2:0]       ack2;
   logic [7:0]       byte2;
   logic             start2;
   logic             tx_done2;
   logic             busy2;
   logic [1:0]       gid2;

   always #5 clk = ~clk;

   tx_arbiter #(.NUM_REQ(NR), .WORD_WIDTH(WW)) dut (
      .clk(clk), .rst_in(rst_in), .req_i(req_i), .data_i(data_i), .ack_o(ack_o),
      .byte_o(byte_o), .start_o(start_o), .tx_done_i(tx_done_i), .busy_o(busy_o),
      .grant_id_o(grant_id_o)
   );

   tx_arbiter #(.NUM_REQ(3), .WORD_WIDTH(13)) dut13 (
      .clk(clk), .rst_in(rst2), .req_i(req2), .data_i(data2), .ack_o(ack2),
      .byte_o(byte2), .start_o(start2), .tx_done_i(tx_done2), .busy_o(busy2),
      .grant_id_o(gid2)
   );

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] exp_b[$];
   logic [2:0] exp_a[$];
   logic [7:0] obs_b[$];
   logic [2:0] obs_a[$];
   logic [1:0] obs_g[$];
   logic [7:0] e8, o8;
   logic [2:0] ea, oa;
   int         s0;
   bit         ok;

   int  uart_delay = 2;
   int  uart_low   = 3;
   bit  idle_level = 1'b1;

   int  cyc = 0, last_ack_cyc = -10, start_cyc = 0;
   int  stab_err = 0, hot_err = 0, gap_err = 0;
   bit  m_prev_start = 1'b0, m_prev_busy = 1'b0;
   logic [7:0] m_cur = 8'h00;

   // UART model: after start_o is seen, waits uart_delay cycles, drops
   // tx_done for uart_low cycles, raises it one cycle, then rests at idle_level.
   initial begin
      tx_done_i = 1'b1;
      forever begin
         if (start_o === 1'b1) begin
            repeat (uart_delay) begin @(posedge clk); #1; end
            tx_done_i = 1'b0;
            repeat (uart_low) begin @(posedge clk); #1; end
            tx_done_i = 1'b1;
            @(posedge clk); #1;
            tx_done_i = idle_level;
         end else begin
            @(posedge clk); #1;
            tx_done_i = idle_level;
         end
      end
   end

   // Monitor: records DUT output events for the tasks to compare.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_in === 1'b0) begin
            if (start_o && !m_prev_start) begin
               obs_b.push_back(byte_o);
               m_cur = byte_o;
            end else if (busy_o && (byte_o !== m_cur)) stab_err++;
            if (start_o) start_cyc++;
            if (busy_o && !m_prev_busy) begin
               obs_g.push_back(grant_id_o);
               if (cyc - last_ack_cyc < 2) gap_err++;
            end
            if (ack_o != '0) begin
               obs_a.push_back(ack_o);
               last_ack_cyc = cyc;
            end
            if ($countones(ack_o) > 1) hot_err++;
         end
         m_prev_start = start_o;
         m_prev_busy  = busy_o;
      end
   end

   task automatic wait_busy(input int budget);
      int c = 0;
      while (!busy_o && c < budget) begin @(negedge clk); c++; end
   endtask

   task automatic wait_acks(input int n, input int budget, output bit done);
      int c = 0;
      done = (obs_a.size() >= n);
      while (!done && c < budget) begin
         @(negedge clk); c++;
         if (obs_a.size() >= n) done = 1'b1;
      end
   endtask

   task automatic clear_obs();
      obs_b.delete(); obs_a.delete(); obs_g.delete();
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      repeat (3) @(negedge clk);
      rst_in = 1'b0;
      @(negedge clk);
      n_chk++; if (byte_o !== 8'h00) begin n_err++; $display("FAIL reset_byte got=%h exp=00", byte_o); end
      n_chk++; if (start_o !== 1'b0) begin n_err++; $display("FAIL reset_start got=%b exp=0", start_o); end
      n_chk++; if (ack_o !== 3'b000) begin n_err++; $display("FAIL reset_ack got=%b exp=000", ack_o); end
      n_chk++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
      n_chk++; if (grant_id_o !== 2'd0) begin n_err++; $display("FAIL reset_gid got=%0d exp=0", grant_id_o); end
      clear_obs();
   endtask

   task automatic test_single();
      data_i[1*WW +: WW] = 16'h1ABC;
      exp_b.push_back(8'hA1); exp_b.push_back(8'h1A); exp_b.push_back(8'hBC);
      exp_a.push_back(3'b010);
      s0 = start_cyc;
      req_i = 3'b010;
      @(negedge clk);
      wait_busy(20);
      n_chk++; if (grant_id_o !== 2'd1) begin n_err++; $display("FAIL single_gid got=%0d exp=1", grant_id_o); end
      req_i = 3'b000;
      wait_acks(1, 200, ok);
      n_chk++; if (!ok) begin n_err++; $display("FAIL single_timeout acks=%0d exp=1", obs_a.size()); end
      repeat (5) @(negedge clk);
      while (exp_b.size() > 0) begin
         e8 = exp_b.pop_front(); o8 = 8'hxx;
         if (obs_b.size() > 0) o8 = obs_b.pop_front();
         n_chk++; if (o8 !== e8) begin n_err++; $display("FAIL single_byte got=%h exp=%h", o8, e8); end
      end
      while (exp_a.size() > 0) begin
         ea = exp_a.pop_front(); oa = 3'bxxx;
         if (obs_a.size() > 0) oa = obs_a.pop_front();
         n_chk++; if (oa !== ea) begin n_err++; $display("FAIL single_ack got=%b exp=%b", oa, ea); end
      end
      n_chk++; if (obs_a.size() != 0) begin n_err++; $display("FAIL single_extra_ack got=%0d exp=0", obs_a.size()); end
      // start_o holds until tx_done low is sampled: 3 cycles per byte here
      n_chk++; if (start_cyc - s0 != 9) begin n_err++; $display("FAIL single_start_cycles got=%0d exp=9", start_cyc - s0); end
      clear_obs();
   endtask

   task automatic test_all();
      logic [15:0] w[3];
      int          c;
      w[0] = 16'h1A78; w[1] = 16'h2B69; w[2] = 16'h3C5A;
      rst_in = 1'b1;
      repeat (2) @(negedge clk);
      rst_in = 1'b0;
      clear_obs();
      data_i = {w[2], w[1], w[0]};
      for (int p = 0; p < 4; p++) begin
         exp_b.push_back(8'hA0 | 8'(p % 3));
         exp_b.push_back(w[p % 3][15:8]);
         exp_b.push_back(w[p % 3][7:0]);
         exp_a.push_back(3'(1 << (p % 3)));
      end
      req_i = 3'b111;
      c = 0;
      while (obs_g.size() < 4 && c < 400) begin @(negedge clk); c++; end
      req_i = 3'b000;
      wait_acks(4, 200, ok);
      n_chk++; if (!ok) begin n_err++; $display("FAIL all_timeout acks=%0d exp=4", obs_a.size()); end
      for (int p = 0; p < 4; p++) begin
         oa = 3'bxxx;
         if (obs_g.size() > 0) oa = 3'(obs_g.pop_front());
         n_chk++; if (oa !== 3'(p % 3)) begin n_err++; $display("FAIL all_order pkt=%0d got=%0d exp=%0d", p, oa, p % 3); end
      end
      while (exp_b.size() > 0) begin
         e8 = exp_b.pop_front(); o8 = 8'hxx;
         if (obs_b.size() > 0) o8 = obs_b.pop_front();
         n_chk++; if (o8 !== e8) begin n_err++; $display("FAIL all_byte got=%h exp=%h", o8, e8); end
      end
      while (exp_a.size() > 0) begin
         ea = exp_a.pop_front(); oa = 3'bxxx;
         if (obs_a.size() > 0) oa = obs_a.pop_front();
         n_chk++; if (oa !== ea) begin n_err++; $display("FAIL all_ack got=%b exp=%b", oa, ea); end
      end
      clear_obs();
   endtask

   task automatic test_data_change();
      data_i[0 +: WW] = 16'h55AA;
      exp_b.push_back(8'hA0); exp_b.push_back(8'h55); exp_b.push_back(8'hAA);
      req_i = 3'b001;
      @(negedge clk);
      wait_busy(20);
      data_i[0 +: WW] = 16'hFFFF;
      req_i = 3'b000;
      wait_acks(1, 200, ok);
      n_chk++; if (!ok) begin n_err++; $display("FAIL chg_timeout acks=%0d exp=1", obs_a.size()); end
      while (exp_b.size() > 0) begin
         e8 = exp_b.pop_front(); o8 = 8'hxx;
         if (obs_b.size() > 0) o8 = obs_b.pop_front();
         n_chk++; if (o8 !== e8) begin n_err++; $display("FAIL chg_byte got=%h exp=%h", o8, e8); end
      end
      clear_obs();
   endtask

   task automatic test_slow();
      idle_level = 1'b0; uart_delay = 0; uart_low = 10;
      repeat (3) @(negedge clk);
      data_i[2*WW +: WW] = 16'h0102;
      exp_b.push_back(8'hA2); exp_b.push_back(8'h01); exp_b.push_back(8'h02);
      exp_a.push_back(3'b100);
      s0 = start_cyc;
      req_i = 3'b100;
      @(negedge clk);
      wait_busy(20);
      req_i = 3'b000;
      wait_acks(1, 300, ok);
      n_chk++; if (!ok) begin n_err++; $display("FAIL slow_timeout acks=%0d exp=1", obs_a.size()); end
      repeat (15) @(negedge clk);
      n_chk++; if (obs_b.size() != 3) begin n_err++; $display("FAIL slow_count got=%0d exp=3", obs_b.size()); end
      n_chk++; if (start_cyc - s0 != 3) begin n_err++; $display("FAIL slow_start_cycles got=%0d exp=3", start_cyc - s0); end
      while (exp_b.size() > 0) begin
         e8 = exp_b.pop_front(); o8 = 8'hxx;
         if (obs_b.size() > 0) o8 = obs_b.pop_front();
         n_chk++; if (o8 !== e8) begin n_err++; $display("FAIL slow_byte got=%h exp=%h", o8, e8); end
      end
      while (exp_a.size() > 0) begin
         ea = exp_a.pop_front(); oa = 3'bxxx;
         if (obs_a.size() > 0) oa = obs_a.pop_front();
         n_chk++; if (oa !== ea) begin n_err++; $display("FAIL slow_ack got=%b exp=%b", oa, ea); end
      end
      idle_level = 1'b1; uart_delay = 2; uart_low = 3;
      repeat (3) @(negedge clk);
      clear_obs();
   endtask

   task automatic test_reset_mid();
      int c = 0;
      data_i[1*WW +: WW] = 16'h7E81;
      req_i = 3'b010;
      while (obs_b.size() < 2 && c < 100) begin @(negedge clk); c++; end
      n_chk++; if (obs_b.size() < 2) begin n_err++; $display("FAIL rmid_timeout bytes=%0d exp=2", obs_b.size()); end
      rst_in = 1'b1; req_i = 3'b000;
      @(negedge clk);
      n_chk++; if (start_o !== 1'b0) begin n_err++; $display("FAIL rmid_start got=%b exp=0", start_o); end
      n_chk++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rmid_busy got=%b exp=0", busy_o); end
      n_chk++; if (ack_o !== 3'b000) begin n_err++; $display("FAIL rmid_ack got=%b exp=000", ack_o); end
      rst_in = 1'b0;
      repeat (12) @(negedge clk);
      n_chk++; if (obs_a.size() != 0) begin n_err++; $display("FAIL rmid_no_ack got=%0d exp=0", obs_a.size()); end
      clear_obs();
      data_i[0 +: WW] = 16'h0F0F;
      exp_b.push_back(8'hA0); exp_b.push_back(8'h0F); exp_b.push_back(8'h0F);
      exp_a.push_back(3'b001);
      req_i = 3'b111;
      @(negedge clk);
      wait_busy(20);
      req_i = 3'b000;
      n_chk++; if (grant_id_o !== 2'd0) begin n_err++; $display("FAIL rmid_first_gid got=%0d exp=0", grant_id_o); end
      wait_acks(1, 200, ok);
      n_chk++; if (!ok) begin n_err++; $display("FAIL rmid_ack_timeout acks=%0d exp=1", obs_a.size()); end
      while (exp_b.size() > 0) begin
         e8 = exp_b.pop_front(); o8 = 8'hxx;
         if (obs_b.size() > 0) o8 = obs_b.pop_front();
         n_chk++; if (o8 !== e8) begin n_err++; $display("FAIL rmid_byte got=%h exp=%h", o8, e8); end
      end
      while (exp_a.size() > 0) begin
         ea = exp_a.pop_front(); oa = 3'bxxx;
         if (obs_a.size() > 0) oa = obs_a.pop_front();
         n_chk++; if (oa !== ea) begin n_err++; $display("FAIL rmid_ack got=%b exp=%b", oa, ea); end
      end
      clear_obs();
   endtask

   task automatic test_w13();
      logic [7:0] got[$];
      logic [2:0] ack_seen = 3'b000;
      bit         prev = 1'b0;
      rst2 = 1'b1;
      repeat (2) @(negedge clk);
      rst2 = 1'b0;
      data2[12:0] = 13'h1FFF;
      exp_b.push_back(8'hA0); exp_b.push_back(8'h1F); exp_b.push_back(8'hFF);
      req2 = 3'b001;
      for (int c = 0; c < 100 && ack_seen == 3'b000; c++) begin
         @(negedge clk);
         if (busy2) req2 = 3'b000;
         if (start2 && !prev) got.push_back(byte2);
         if (ack2 != 3'b000) ack_seen = ack2;
         prev = start2;
         tx_done2 = !start2;
      end
      n_chk++; if (ack_seen !== 3'b001) begin n_err++; $display("FAIL w13_ack got=%b exp=001", ack_seen); end
      while (exp_b.size() > 0) begin
         e8 = exp_b.pop_front(); o8 = 8'hxx;
         if (got.size() > 0) o8 = got.pop_front();
         n_chk++; if (o8 !== e8) begin n_err++; $display("FAIL w13_byte got=%h exp=%h", o8, e8); end
      end
   endtask

   task automatic test_invariants();
      n_chk++; if (stab_err != 0) begin n_err++; $display("FAIL byte_stable got=%0d exp=0", stab_err); end
      n_chk++; if (hot_err != 0) begin n_err++; $display("FAIL ack_onehot got=%0d exp=0", hot_err); end
      n_chk++; if (gap_err != 0) begin n_err++; $display("FAIL idle_gap got=%0d exp=0", gap_err); end
   endtask

   initial begin
      rst_in = 1'b1; req_i = '0; data_i = '0;
      rst2 = 1'b1; req2 = '0; data2 = '0; tx_done2 = 1'b1;
      test_reset();
      test_single();
      test_all();
      test_data_change();
      test_slow();
      test_reset_mid();
      test_w13();
      test_invariants();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of requesters (range 1..16).
REQ-002 SHALL have parameter WORD_WIDTH, default 16, requester word width (range 9..16).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on posedge.
REQ-004 SHALL have port rst_in  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_i  input  NUM_REQ  per-requester send request, level.
REQ-006 SHALL have port data_i  input  NUM_REQ*WORD_WIDTH  word of requester k at bits [k*WORD_WIDTH +: WORD_WIDTH].
REQ-007 SHALL have port ack_o  output  NUM_REQ  one-cycle pulse on bit k when requester k's word is fully transmitted.
REQ-008 SHALL have port byte_o  output  8  byte presented to the shared UART transmitter.
REQ-009 SHALL have port start_o  output  1  transmit start to the UART.
REQ-010 SHALL have port tx_done_i  input  1  UART idle flag; high = free, low = transmitting.
REQ-011 SHALL have port busy_o  output  1  high while a packet is in progress.
REQ-012 SHALL have port grant_id_o  output  max(1,$clog2(NUM_REQ))  index of the current or last granted requester.

Function
REQ-013 SHALL send each granted word as one 3-byte packet, in this order: header {4'hA, id zero-extended to 4 bits}, upper byte, lower byte.
REQ-014 SHALL form the upper byte as word[WORD_WIDTH-1:8] zero-extended to 8 bits and the lower byte as word[7:0].
REQ-015 SHALL use the FSM states IDLE, START and WAIT_DONE, with a 2-bit byte index (0..2).
REQ-016 In IDLE with any req_i bit set, SHALL grant round-robin, searching from (last_grant+1) mod NUM_REQ upward.
REQ-017 On grant, SHALL, in the same cycle, latch the id and that requester's word, load byte_o with the header, set byte index 0, assert busy_o and go to START.
REQ-018 In START, SHALL hold start_o high until tx_done_i is sampled low, then deassert start_o and go to WAIT_DONE.
REQ-019 In WAIT_DONE with tx_done_i high and byte index below 2, SHALL increment the index, load the next byte on byte_o and go to START.
REQ-020 In WAIT_DONE with tx_done_i high and byte index 2, SHALL pulse ack_o[id] for exactly one cycle, deassert busy_o and return to IDLE.
REQ-021 Back-to-back packets SHALL have at least one IDLE cycle between ack_o and the next grant.
REQ-022 SHALL ignore changes on data_i after grant; the packet uses only the latched word.
REQ-023 Deassertion of req_i mid-packet SHALL NOT abort the packet; the packet completes and ack_o still pulses.
REQ-024 A requester still asserting req_i in the cycle after its ack_o SHALL be treated as a new request, subject to round-robin order.
REQ-025 byte_o SHALL remain stable from the cycle start_o rises until the state leaves WAIT_DONE.
REQ-026 When tx_done_i is low on arrival in START, SHALL keep start_o high and wait; no byte is skipped.
REQ-027 SHALL keep at most one ack_o bit high in any cycle.

Reset
REQ-028 On rst_in high, SHALL force: state IDLE, byte_o 0, start_o 0, ack_o 0, busy_o 0, grant_id_o 0, byte index 0.
REQ-029 On reset, SHALL set last_grant to NUM_REQ-1, so requester 0 has priority first.
REQ-030 Reset mid-packet SHALL abandon the packet with no ack_o pulse, and start_o SHALL drop in the cycle after rst_in is sampled.

Structure
REQ-031 A shared package tx_arbiter_pkg SHALL hold the state enum type and the header nibble constant HDR_NIBBLE = 4'hA.
REQ-032 Round-robin selection SHALL live in sub-module rr_arbiter (inputs: request vector, last_grant; outputs: valid, grant index), combinational.

Verification
REQ-033 Single request: req_i=3'b010, word 16'h1ABC, UART model drops tx_done_i 2 cycles after start -> bytes 8'hA1, 8'h1A, 8'hBC, then one ack_o[1] pulse.
REQ-034 All requesting after reset: req_i=3'b111 held -> packets granted in id order 0, 1, 2, 0, each with the correct header.
REQ-035 Data change mid-packet: data_i changed after grant -> the transmitted bytes match the latched word.
REQ-036 Slow UART: tx_done_i stays low 10 cycles after start and is low on START entry -> start_o held until tx_done_i low is sampled; exactly 3 bytes sent, none duplicated.
REQ-037 Reset during the upper byte -> next cycle start_o=0, busy_o=0, no ack_o; a following request from id 0 is granted first.
REQ-038 WORD_WIDTH=13 with word 13'h1FFF -> upper byte 8'h1F, lower byte 8'hFF.
